// File: rtl/mmio_arbiter_pkg.sv
// Shared types and constants for the two-requester MMIO arbiter.
// The FSM encoding and error data word are kept here so that every user agrees on them.
package mmio_arbiter_pkg;

  typedef enum logic [1:0] {
    MARB_IDLE  = 2'd0,
    MARB_ISSUE = 2'd1,
    MARB_WAIT  = 2'd2,
    MARB_RESP  = 2'd3
  } marb_state_t;

  localparam logic [31:0] MARB_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          MARB_CNT_W    = 8;

  // Only lane 0 decides whether a transaction waits for read data.
  function automatic logic marb_is_read(input logic oe0, input logic we0);
    return oe0 & ~we0;
  endfunction

endpackage

// File: rtl/mmio_arbiter_if.sv
// Bundle of both requester ports plus the downstream MMIO port.
// slave is the arbiter's view; master is the view of the requesters and the MMIO target.
interface mmio_arbiter_if #(
  parameter int MEM_SCALE = 27
);

  logic                 m0_req,    m1_req;
  logic [3:0]           m0_oe,     m1_oe;
  logic [3:0]           m0_we,     m1_we;
  logic [MEM_SCALE-1:0] m0_addr,   m1_addr;
  logic [31:0]          m0_wdata,  m1_wdata;
  logic                 m0_gnt,    m1_gnt;
  logic                 m0_rvalid, m1_rvalid;
  logic [31:0]          m0_rdata,  m1_rdata;

  logic [3:0]           oe;
  logic [3:0]           we;
  logic [MEM_SCALE-1:0] addr;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 valid;
  logic                 busy;
  logic                 timeout_err;

  modport slave (
    input  m0_req, m1_req, m0_oe, m1_oe, m0_we, m1_we,
           m0_addr, m1_addr, m0_wdata, m1_wdata, rdata, valid,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           oe, we, addr, wdata, busy, timeout_err
  );

  modport master (
    output m0_req, m1_req, m0_oe, m1_oe, m0_we, m1_we,
           m0_addr, m1_addr, m0_wdata, m1_wdata, rdata, valid,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           oe, we, addr, wdata, busy, timeout_err
  );

endinterface

// File: rtl/mmio_rr_pick.sv
// Combinational 2-way round-robin picker.
// On a tie the requester that did not own the port last time wins.
module mmio_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       pick,
  output logic       any
);

  always_comb begin
    any  = |req;
    pick = (req == 2'b11) ? ~last_owner : req[1];
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Serialises CPU (requester 0) and host loader (requester 1) accesses onto the single MMIO port.
// Every output is registered; a read with no valid response completes with an error word.
module mmio_arbiter
  import mmio_arbiter_pkg::*;
#(
  parameter int MEM_SCALE = 27,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst_x,
  mmio_arbiter_if.slave bus
);

  localparam logic [MARB_CNT_W-1:0] TIMEOUT_CNT = MARB_CNT_W'(TIMEOUT);

  marb_state_t           state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [MARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pick, any;

  logic [3:0]            oe_q, oe_d;
  logic [3:0]            we_q, we_d;
  logic [MEM_SCALE-1:0]  addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [31:0]           rdata0_q, rdata0_d;
  logic [31:0]           rdata1_q, rdata1_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  resp_go;
  logic [31:0]           resp_data;

  mmio_rr_pick u_pick (
    .req        ({bus.m1_req, bus.m0_req}),
    .last_owner (last_owner_q),
    .pick       (pick),
    .any        (any)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) state_q <= MARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MARB_IDLE:  if (any) state_d = MARB_ISSUE;
      MARB_ISSUE: state_d = marb_is_read(oe_q[0], we_q[0]) ? MARB_WAIT : MARB_RESP;
      MARB_WAIT:  if (bus.valid || (cnt_q == TIMEOUT_CNT)) state_d = MARB_RESP;
      MARB_RESP:  state_d = MARB_IDLE;
      default:    state_d = MARB_IDLE;
    endcase
  end

  // The strobe registers double as the payload latch: they hold the winner's
  // request through ISSUE, which is also when the read/write decision is made.
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    oe_d         = '0;
    we_d         = '0;
    addr_d       = '0;
    wdata_d      = '0;
    gnt_d        = '0;
    rvalid_d     = '0;
    rdata0_d     = '0;
    rdata1_d     = '0;
    resp_go      = 1'b0;
    resp_data    = '0;
    case (state_q)
      MARB_IDLE: begin
        if (any) begin
          owner_d     = pick;
          gnt_d[pick] = 1'b1;
          oe_d        = pick ? bus.m1_oe    : bus.m0_oe;
          we_d        = pick ? bus.m1_we    : bus.m0_we;
          addr_d      = pick ? bus.m1_addr  : bus.m0_addr;
          wdata_d     = pick ? bus.m1_wdata : bus.m0_wdata;
        end
      end
      MARB_ISSUE: begin
        cnt_d = '0;
        if (!marb_is_read(oe_q[0], we_q[0])) resp_go = 1'b1;
      end
      MARB_WAIT: begin
        if (bus.valid) begin
          resp_go   = 1'b1;
          resp_data = bus.rdata;
        end else if (cnt_q == TIMEOUT_CNT) begin
          resp_go   = 1'b1;
          resp_data = MARB_ERR_DATA;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MARB_RESP: last_owner_d = owner_q;
      default: ;
    endcase
    if (resp_go) begin
      rvalid_d[owner_q] = 1'b1;
      if (owner_q) rdata1_d = resp_data;
      else         rdata0_d = resp_data;
    end
  end

  assign busy_d = (state_d != MARB_IDLE);

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      oe_q         <= '0;
      we_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.m0_gnt      = gnt_q[0];
  assign bus.m1_gnt      = gnt_q[1];
  assign bus.m0_rvalid   = rvalid_q[0];
  assign bus.m1_rvalid   = rvalid_q[1];
  assign bus.m0_rdata    = rdata0_q;
  assign bus.m1_rdata    = rdata1_q;
  assign bus.oe          = oe_q;
  assign bus.we          = we_q;
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;

endmodule
